difftest_arch_state: RTL and testbench

DIFFTEST_ARCH_STATE -- requirements
Module: difftest_arch_state

---
 rtl/difftest_arch_state_pkg.sv | 26 ++
 rtl/difftest_arch_state_arch_snap_reg.sv | 18 +
 rtl/difftest_arch_state.sv | 101 ++++++++++
 tb/tb_difftest_arch_state.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_arch_state_pkg.sv
// difftest_arch_state_pkg: shared sizes and snapshot index map for the arch-state capture block
package difftest_arch_state_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NCSR = 18;
  localparam int NVAL = 2 * NREG + NCSR;
  localparam int CSR_PRIV = 64;
  localparam int CSR_MSTATUS = 65;
  localparam int CSR_SSTATUS = 66;
  localparam int CSR_MEPC = 67;
  localparam int CSR_SEPC = 68;
  localparam int CSR_MTVAL = 69;
  localparam int CSR_STVAL = 70;
  localparam int CSR_MTVEC = 71;
  localparam int CSR_STVEC = 72;
  localparam int CSR_MCAUSE = 73;
  localparam int CSR_SCAUSE = 74;
  localparam int CSR_SATP = 75;
  localparam int CSR_MIP = 76;
  localparam int CSR_MIE = 77;
  localparam int CSR_MSCRATCH = 78;
  localparam int CSR_SSCRATCH = 79;
  localparam int CSR_MIDELEG = 80;
  localparam int CSR_MEDELEG = 81;
  localparam int RISCV_PRIV_MODE_M = 3;
endpackage

// File: rtl/difftest_arch_state_arch_snap_reg.sv
// arch_snap_reg: one captured architectural value plus a flag telling whether the incoming value differs from it
module arch_snap_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         diff_o
);
  logic [W-1:0] q_q;
  // capture every edge; snapshot clears asynchronously on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else        q_q <= d_i;
  assign q_o    = q_q;
  assign diff_o = d_i != q_q;
endmodule

// File: rtl/difftest_arch_state.sv
// difftest_arch_state: per-cycle snapshot of GPR/FPR/CSR state with change detection and indexed readback
module difftest_arch_state #(
  parameter int XLEN = difftest_arch_state_pkg::XLEN,
  parameter int NREG = difftest_arch_state_pkg::NREG
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic [7:0]      coreid,
  input  logic [XLEN-1:0] gpr_0, gpr_1, gpr_2, gpr_3, gpr_4, gpr_5, gpr_6, gpr_7,
  input  logic [XLEN-1:0] gpr_8, gpr_9, gpr_10, gpr_11, gpr_12, gpr_13, gpr_14, gpr_15,
  input  logic [XLEN-1:0] gpr_16, gpr_17, gpr_18, gpr_19, gpr_20, gpr_21, gpr_22, gpr_23,
  input  logic [XLEN-1:0] gpr_24, gpr_25, gpr_26, gpr_27, gpr_28, gpr_29, gpr_30, gpr_31,
  input  logic [XLEN-1:0] fpr_0, fpr_1, fpr_2, fpr_3, fpr_4, fpr_5, fpr_6, fpr_7,
  input  logic [XLEN-1:0] fpr_8, fpr_9, fpr_10, fpr_11, fpr_12, fpr_13, fpr_14, fpr_15,
  input  logic [XLEN-1:0] fpr_16, fpr_17, fpr_18, fpr_19, fpr_20, fpr_21, fpr_22, fpr_23,
  input  logic [XLEN-1:0] fpr_24, fpr_25, fpr_26, fpr_27, fpr_28, fpr_29, fpr_30, fpr_31,
  input  logic [XLEN-1:0] priviledgeMode,
  input  logic [XLEN-1:0] mstatus, sstatus, mepc, sepc, mtval, stval, mtvec, stvec,
  input  logic [XLEN-1:0] mcause, scause, satp, mip, mie, mscratch, sscratch, mideleg, medeleg,
  input  logic [6:0]      rd_sel,
  output logic [XLEN-1:0] rd_data,
  output logic            snap_valid,
  output logic [7:0]      snap_coreid,
  output logic            state_changed,
  output logic            gpr0_err
);
  import difftest_arch_state_pkg::*;
  logic [NREG-1:0][XLEN-1:0] gpr_v, fpr_v;
  logic [XLEN-1:0] vals [NVAL];
  logic [XLEN-1:0] snap [NVAL];
  logic [XLEN-1:0] rd_tab [128];
  logic [NVAL-1:0] diff;
  logic [7:0] snap_coreid_q;
  logic snap_valid_q, state_changed_q, state_changed_d, gpr0_err_q, gpr0_err_d;
  assign gpr_v = {gpr_31, gpr_30, gpr_29, gpr_28, gpr_27, gpr_26, gpr_25, gpr_24,
                  gpr_23, gpr_22, gpr_21, gpr_20, gpr_19, gpr_18, gpr_17, gpr_16,
                  gpr_15, gpr_14, gpr_13, gpr_12, gpr_11, gpr_10, gpr_9, gpr_8,
                  gpr_7, gpr_6, gpr_5, gpr_4, gpr_3, gpr_2, gpr_1, gpr_0};
  assign fpr_v = {fpr_31, fpr_30, fpr_29, fpr_28, fpr_27, fpr_26, fpr_25, fpr_24,
                  fpr_23, fpr_22, fpr_21, fpr_20, fpr_19, fpr_18, fpr_17, fpr_16,
                  fpr_15, fpr_14, fpr_13, fpr_12, fpr_11, fpr_10, fpr_9, fpr_8,
                  fpr_7, fpr_6, fpr_5, fpr_4, fpr_3, fpr_2, fpr_1, fpr_0};
  assign vals[CSR_PRIV]     = priviledgeMode;
  assign vals[CSR_MSTATUS]  = mstatus;
  assign vals[CSR_SSTATUS]  = sstatus;
  assign vals[CSR_MEPC]     = mepc;
  assign vals[CSR_SEPC]     = sepc;
  assign vals[CSR_MTVAL]    = mtval;
  assign vals[CSR_STVAL]    = stval;
  assign vals[CSR_MTVEC]    = mtvec;
  assign vals[CSR_STVEC]    = stvec;
  assign vals[CSR_MCAUSE]   = mcause;
  assign vals[CSR_SCAUSE]   = scause;
  assign vals[CSR_SATP]     = satp;
  assign vals[CSR_MIP]      = mip;
  assign vals[CSR_MIE]      = mie;
  assign vals[CSR_MSCRATCH] = mscratch;
  assign vals[CSR_SSCRATCH] = sscratch;
  assign vals[CSR_MIDELEG]  = mideleg;
  assign vals[CSR_MEDELEG]  = medeleg;
  for (genvar g = 0; g < NREG; g++) begin : g_rf
    assign vals[g]        = gpr_v[g];
    assign vals[NREG + g] = fpr_v[g];
  end
  for (genvar v = 0; v < NVAL; v++) begin : g_snap
    arch_snap_reg #(.W(XLEN)) u_reg (
      .clk   (clock),
      .rst_n (rst_n),
      .d_i   (vals[v]),
      .q_o   (snap[v]),
      .diff_o(diff[v])
    );
  end
  for (genvar r = 0; r < 128; r++) begin : g_rd
    if (r < NVAL) begin : g_hit
      assign rd_tab[r] = snap[r];
    end else begin : g_miss
      assign rd_tab[r] = '0;
    end
  end
  assign rd_data = rd_tab[rd_sel];
  assign state_changed_d = snap_valid_q & ((|diff) | (coreid != snap_coreid_q));
  assign gpr0_err_d = gpr0_err_q | (gpr_0 != '0);
  // status flags: validity, registered change detect, sticky gpr_0 error
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      snap_coreid_q   <= '0;
      snap_valid_q    <= 1'b0;
      state_changed_q <= 1'b0;
      gpr0_err_q      <= 1'b0;
    end else begin
      snap_coreid_q   <= coreid;
      snap_valid_q    <= 1'b1;
      state_changed_q <= state_changed_d;
      gpr0_err_q      <= gpr0_err_d;
    end
  assign snap_valid    = snap_valid_q;
  assign snap_coreid   = snap_coreid_q;
  assign state_changed = state_changed_q;
  assign gpr0_err      = gpr0_err_q;
endmodule

// File: tb/tb_difftest_arch_state.sv
// tb_difftest_arch_state: directed checks of capture, readback map, change detection and reset
module tb_difftest_arch_state;
  import difftest_arch_state_pkg::*;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] coreid = '0;
  logic [63:0] gpr [32];
  logic [63:0] fpr [32];
  logic [63:0] priv = '0, mstatus = '0, sstatus = '0, mepc = '0, sepc = '0, mtval = '0;
  logic [63:0] stval = '0, mtvec = '0, stvec = '0, mcause = '0, scause = '0, satp = '0;
  logic [63:0] mip = '0, mie = '0, mscratch = '0, sscratch = '0, mideleg = '0, medeleg = '0;
  logic [6:0] rd_sel = '0;
  logic [63:0] rd_data;
  logic snap_valid, state_changed, gpr0_err;
  logic [7:0] snap_coreid;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  difftest_arch_state dut (
    .clock(clock), .rst_n(rst_n), .coreid(coreid),
    .gpr_0(gpr[0]), .gpr_1(gpr[1]), .gpr_2(gpr[2]), .gpr_3(gpr[3]),
    .gpr_4(gpr[4]), .gpr_5(gpr[5]), .gpr_6(gpr[6]), .gpr_7(gpr[7]),
    .gpr_8(gpr[8]), .gpr_9(gpr[9]), .gpr_10(gpr[10]), .gpr_11(gpr[11]),
    .gpr_12(gpr[12]), .gpr_13(gpr[13]), .gpr_14(gpr[14]), .gpr_15(gpr[15]),
    .gpr_16(gpr[16]), .gpr_17(gpr[17]), .gpr_18(gpr[18]), .gpr_19(gpr[19]),
    .gpr_20(gpr[20]), .gpr_21(gpr[21]), .gpr_22(gpr[22]), .gpr_23(gpr[23]),
    .gpr_24(gpr[24]), .gpr_25(gpr[25]), .gpr_26(gpr[26]), .gpr_27(gpr[27]),
    .gpr_28(gpr[28]), .gpr_29(gpr[29]), .gpr_30(gpr[30]), .gpr_31(gpr[31]),
    .fpr_0(fpr[0]), .fpr_1(fpr[1]), .fpr_2(fpr[2]), .fpr_3(fpr[3]),
    .fpr_4(fpr[4]), .fpr_5(fpr[5]), .fpr_6(fpr[6]), .fpr_7(fpr[7]),
    .fpr_8(fpr[8]), .fpr_9(fpr[9]), .fpr_10(fpr[10]), .fpr_11(fpr[11]),
    .fpr_12(fpr[12]), .fpr_13(fpr[13]), .fpr_14(fpr[14]), .fpr_15(fpr[15]),
    .fpr_16(fpr[16]), .fpr_17(fpr[17]), .fpr_18(fpr[18]), .fpr_19(fpr[19]),
    .fpr_20(fpr[20]), .fpr_21(fpr[21]), .fpr_22(fpr[22]), .fpr_23(fpr[23]),
    .fpr_24(fpr[24]), .fpr_25(fpr[25]), .fpr_26(fpr[26]), .fpr_27(fpr[27]),
    .fpr_28(fpr[28]), .fpr_29(fpr[29]), .fpr_30(fpr[30]), .fpr_31(fpr[31]),
    .priviledgeMode(priv), .mstatus(mstatus), .sstatus(sstatus), .mepc(mepc),
    .sepc(sepc), .mtval(mtval), .stval(stval), .mtvec(mtvec), .stvec(stvec),
    .mcause(mcause), .scause(scause), .satp(satp), .mip(mip), .mie(mie),
    .mscratch(mscratch), .sscratch(sscratch), .mideleg(mideleg), .medeleg(medeleg),
    .rd_sel(rd_sel), .rd_data(rd_data), .snap_valid(snap_valid),
    .snap_coreid(snap_coreid), .state_changed(state_changed), .gpr0_err(gpr0_err)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) begin
      gpr[i] = '0;
      fpr[i] = '0;
    end
    #2;
    n_checks++;
    if ({snap_valid, state_changed, gpr0_err, snap_coreid} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0", {snap_valid, state_changed, gpr0_err, snap_coreid});
    end
    rd_sel = 7'd10; #1;
    n_checks++;
    if (rd_data !== 64'd0) begin n_fail++; $display("FAIL reset_rd10: got %h expected 0", rd_data); end
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    gpr[10] = 64'h1234;
    step();
    rd_sel = 7'd10; #1;
    n_checks++;
    if (rd_data !== 64'h1234) begin n_fail++; $display("FAIL capture_gpr10: got %h expected 1234", rd_data); end
    n_checks++;
    if (snap_valid !== 1'b1) begin n_fail++; $display("FAIL capture_valid: got %b expected 1", snap_valid); end
    n_checks++;
    if (state_changed !== 1'b0) begin n_fail++; $display("FAIL capture_first_change: got %b expected 0", state_changed); end
  endtask

  task automatic test_change();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (state_changed !== 1'b0) begin n_fail++; $display("FAIL hold_change_%0d: got %b expected 0", i, state_changed); end
    end
    mepc = 64'h8000_0010;
    step();
    n_checks++;
    if (state_changed !== 1'b1) begin n_fail++; $display("FAIL mepc_change: got %b expected 1", state_changed); end
    rd_sel = 7'd67; #1;
    n_checks++;
    if (rd_data !== 64'h8000_0010) begin n_fail++; $display("FAIL mepc_read: got %h expected 80000010", rd_data); end
    step();
    n_checks++;
    if (state_changed !== 1'b0) begin n_fail++; $display("FAIL mepc_one_cycle: got %b expected 0", state_changed); end
  endtask

  task automatic test_csr_map();
    priv = 64'(RISCV_PRIV_MODE_M);
    mstatus = 64'hA_0000_1800;
    medeleg = 64'd0;
    sstatus = 64'h5;
    step();
    rd_sel = 7'd64; #1;
    n_checks++;
    if (rd_data !== 64'd3) begin n_fail++; $display("FAIL csr_priv: got %h expected 3", rd_data); end
    rd_sel = 7'd65; #1;
    n_checks++;
    if (rd_data !== 64'hA_0000_1800) begin n_fail++; $display("FAIL csr_mstatus: got %h expected a00001800", rd_data); end
    rd_sel = 7'd66; #1;
    n_checks++;
    if (rd_data !== 64'h5) begin n_fail++; $display("FAIL csr_sstatus: got %h expected 5", rd_data); end
    rd_sel = 7'd81; #1;
    n_checks++;
    if (rd_data !== 64'd0) begin n_fail++; $display("FAIL csr_medeleg: got %h expected 0", rd_data); end
    n_checks++;
    if (state_changed !== 1'b1) begin n_fail++; $display("FAIL csr_change: got %b expected 1", state_changed); end
  endtask

  task automatic test_gpr0_err();
    step();
    n_checks++;
    if (gpr0_err !== 1'b0) begin n_fail++; $display("FAIL gpr0_err_idle: got %b expected 0", gpr0_err); end
    gpr[0] = 64'd1;
    step();
    n_checks++;
    if (gpr0_err !== 1'b1) begin n_fail++; $display("FAIL gpr0_err_set: got %b expected 1", gpr0_err); end
    rd_sel = 7'd0; #1;
    n_checks++;
    if (rd_data !== 64'd1) begin n_fail++; $display("FAIL gpr0_stored: got %h expected 1", rd_data); end
    gpr[0] = 64'd0;
    step();
    step();
    n_checks++;
    if (gpr0_err !== 1'b1) begin n_fail++; $display("FAIL gpr0_err_sticky: got %b expected 1", gpr0_err); end
  endtask

  task automatic test_fpr_oob();
    fpr[31] = 64'hFFFF_FFFF_FFFF_FFFF;
    fpr[0] = 64'h0BAD_F00D;
    step();
    rd_sel = 7'd63; #1;
    n_checks++;
    if (rd_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL fpr31_read: got %h expected all ones", rd_data); end
    rd_sel = 7'd32; #1;
    n_checks++;
    if (rd_data !== 64'h0BAD_F00D) begin n_fail++; $display("FAIL fpr0_read: got %h expected badf00d", rd_data); end
    rd_sel = 7'd100; #1;
    n_checks++;
    if (rd_data !== 64'd0) begin n_fail++; $display("FAIL oob_100: got %h expected 0", rd_data); end
    rd_sel = 7'd82; #1;
    n_checks++;
    if (rd_data !== 64'd0) begin n_fail++; $display("FAIL oob_82: got %h expected 0", rd_data); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      gpr[5] = 64'(i * 7);
      step();
      n_checks++;
      if (state_changed !== 1'b1) begin n_fail++; $display("FAIL b2b_change_%0d: got %b expected 1", i, state_changed); end
    end
    rd_sel = 7'd5; #1;
    n_checks++;
    if (rd_data !== 64'd28) begin n_fail++; $display("FAIL b2b_gpr5: got %h expected 1c", rd_data); end
    coreid = 8'h3C;
    step();
    n_checks++;
    if (state_changed !== 1'b1 || snap_coreid !== 8'h3C) begin
      n_fail++;
      $display("FAIL coreid_change: got %b/%h expected 1/3c", state_changed, snap_coreid);
    end
    step();
    n_checks++;
    if (state_changed !== 1'b0) begin n_fail++; $display("FAIL coreid_settle: got %b expected 0", state_changed); end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({snap_valid, state_changed, gpr0_err, snap_coreid} !== 11'd0) begin
      n_fail++;
      $display("FAIL midreset_flags: got %b expected 0", {snap_valid, state_changed, gpr0_err, snap_coreid});
    end
    rd_sel = 7'd64; #1;
    n_checks++;
    if (rd_data !== 64'd0) begin n_fail++; $display("FAIL midreset_rd64: got %h expected 0", rd_data); end
    rd_sel = 7'd63; #1;
    n_checks++;
    if (rd_data !== 64'd0) begin n_fail++; $display("FAIL midreset_rd63: got %h expected 0", rd_data); end
    step();
    @(negedge clock);
    rst_n = 1'b1;
    step();
    n_checks++;
    if (snap_valid !== 1'b1 || state_changed !== 1'b0 || gpr0_err !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_first: got valid=%b chg=%b err=%b expected 1/0/0", snap_valid, state_changed, gpr0_err);
    end
    rd_sel = 7'd64; #1;
    n_checks++;
    if (rd_data !== 64'd3) begin n_fail++; $display("FAIL post_reset_priv: got %h expected 3", rd_data); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_change();
    test_csr_map();
    test_gpr0_err();
    test_fpr_oob();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
